// File: rtl/water_flow_pkg.sv
// Shared mode and direction encodings for the water-flow LED controller.
package water_flow_pkg;

    typedef enum logic [1:0] {
        MODE_LEFT   = 2'd0,
        MODE_RIGHT  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/flow_prescaler.sv
// Step-rate prescaler: counts clk cycles and flags the cycle on which the
// LED pattern should advance. Priority: clr > hold > run.
module flow_prescaler #(
    parameter int unsigned DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             hold,
    input  logic             run,
    input  logic [DIV_W-1:0] div_val,
    output logic             step
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // Compare against the live divider value; an overshoot simply wraps modulo 2^DIV_W
    always_comb begin
        cnt_d = cnt_q;
        step  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (hold) begin
            cnt_d = cnt_q;
        end else if (run) begin
            if (cnt_q == div_val) begin
                cnt_d = '0;
                step  = 1'b1;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

endmodule

// File: rtl/water_flow_ctrl.sv
// Running-light LED controller: run gating, mode tracking and the four
// pattern generators (LEFT, RIGHT, BOUNCE, FILL).
module water_flow_ctrl
    import water_flow_pkg::*;
#(
    parameter int unsigned N_LED = 8,
    parameter int unsigned DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_a,
    input  logic             en_b,
    input  logic             pause,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div_val,
    output logic [N_LED-1:0] led,
    output logic             step_tick,
    output logic             wrap
);

    mode_e            mode_in;
    mode_e            mode_q, mode_d;
    dir_e             dir_q, dir_d;
    logic [N_LED-1:0] led_q, led_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             active, run, mode_chg, step;

    assign mode_in  = mode_e'(mode);
    assign active   = en_a | en_b;
    assign run      = active & ~pause;
    assign mode_chg = (mode_in != mode_q);

    function automatic logic [N_LED-1:0] init_pat(input mode_e m);
        logic [N_LED-1:0] p;
        p = '0;
        if (m == MODE_RIGHT) p[N_LED-1] = 1'b1;
        else                 p[0]       = 1'b1;
        return p;
    endfunction

    flow_prescaler #(
        .DIV_W(DIV_W)
    ) u_presc (
        .clk    (clk),
        .rst    (rst),
        .clr    (mode_chg | ~active),
        .hold   (pause),
        .run    (run),
        .div_val(div_val),
        .step   (step)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_LEFT;
            dir_q  <= DIR_UP;
            led_q  <= N_LED'(1);
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            dir_q  <= dir_d;
            led_q  <= led_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    // Next-state: mode change > stop > pause (hold) > run step
    always_comb begin
        mode_d = mode_q;
        dir_d  = dir_q;
        led_d  = led_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        if (mode_chg) begin
            mode_d = mode_in;
            led_d  = init_pat(mode_in);
            dir_d  = DIR_UP;
        end else if (!active) begin
            led_d = init_pat(mode_q);
            dir_d = DIR_UP;
        end else if (step) begin
            tick_d = 1'b1;
            case (mode_q)
                MODE_LEFT: begin
                    led_d  = {led_q[N_LED-2:0], led_q[N_LED-1]};
                    wrap_d = led_q[N_LED-1];
                end
                MODE_RIGHT: begin
                    led_d  = {led_q[0], led_q[N_LED-1:1]};
                    wrap_d = led_q[0];
                end
                MODE_BOUNCE: begin
                    // Direction flips on the step that lands on an end bit, so the
                    // end positions are shown once per period
                    if (dir_q == DIR_UP) begin
                        led_d = led_q << 1;
                        if (led_q[N_LED-2]) dir_d = DIR_DOWN;
                    end else begin
                        led_d = led_q >> 1;
                        if (led_q[1]) begin
                            dir_d  = DIR_UP;
                            wrap_d = 1'b1;
                        end
                    end
                end
                default: begin
                    if (&led_q) begin
                        led_d  = N_LED'(1);
                        wrap_d = 1'b1;
                    end else begin
                        led_d = {led_q[N_LED-2:0], 1'b1};
                    end
                end
            endcase
        end
    end

    // Outputs straight from registers
    always_comb begin
        led       = led_q;
        step_tick = tick_q;
        wrap      = wrap_q;
    end

endmodule

// File: tb/tb_water_flow_ctrl.sv
// Self-checking bench for water_flow_ctrl (N_LED=8): a phase-index model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_water_flow_ctrl;

    localparam int N  = 8;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          en_a, en_b, pause;
    logic [1:0]    mode;
    logic [DW-1:0] div_val;
    logic [N-1:0]  led;
    logic          step_tick, wrap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    water_flow_ctrl #(
        .N_LED(N),
        .DIV_W(DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en_a     (en_a),
        .en_b     (en_b),
        .pause    (pause),
        .mode     (mode),
        .div_val  (div_val),
        .led      (led),
        .step_tick(step_tick),
        .wrap     (wrap)
    );

    // ---------------- behavioural model ----------------
    // The pattern is a pure function of (mode, phase); phase counts steps
    // modulo the pattern period.
    logic [1:0]    m_mode;
    logic [DW-1:0] m_cnt;
    int            m_ph;
    logic [N-1:0]  e_led;
    logic          e_tick, e_wrap;
    bit            model_ok = 1'b0;

    function automatic int period(input logic [1:0] m);
        return (m == 2'd2) ? 2 * N - 2 : N;
    endfunction

    function automatic logic [N-1:0] pattern(input logic [1:0] m, input int ph);
        logic [N-1:0] p;
        int k;
        p = '0;
        case (m)
            2'd0: p[ph] = 1'b1;
            2'd1: p[N-1-ph] = 1'b1;
            2'd2: begin
                k = (ph < N) ? ph : 2 * N - 2 - ph;
                p[k] = 1'b1;
            end
            default: for (int i = 0; i <= ph; i++) p[i] = 1'b1;
        endcase
        return p;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 2'd0; m_cnt = '0; m_ph = 0;
            e_tick = 1'b0; e_wrap = 1'b0;
            model_ok = 1'b1;
        end else begin
            e_tick = 1'b0; e_wrap = 1'b0;
            if (mode != m_mode) begin
                m_mode = mode; m_cnt = '0; m_ph = 0;
            end else if (!(en_a || en_b)) begin
                m_cnt = '0; m_ph = 0;
            end else if (pause) begin
                // frozen
            end else if (m_cnt == div_val) begin
                m_cnt  = '0;
                m_ph   = (m_ph + 1) % period(m_mode);
                e_tick = 1'b1;
                e_wrap = (m_ph == 0);
            end else begin
                m_cnt = m_cnt + 1'b1;
            end
        end
        e_led = pattern(m_mode, m_ph);
    end

    // Per-cycle compare on the falling edge
    always @(negedge clk) begin
        if (model_ok) begin
            checks++;
            if (led !== e_led || step_tick !== e_tick || wrap !== e_wrap) begin
                errors++;
                $display("FAIL model t=%0t led=%h exp=%h tick=%b exp=%b wrap=%b exp=%b",
                         $time, led, e_led, step_tick, e_tick, wrap, e_wrap);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_tick(input string name, input int maxc, output int n);
        bit got;
        got = 1'b0;
        n = 0;
        while (!got && n < maxc) begin
            cyc(1);
            n++;
            if (step_tick) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s timeout got=none exp=tick within %0d", name, maxc);
            n = -1;
        end
    endtask

    task automatic wait_led(input string name, input logic [N-1:0] val, input int maxc);
        int n;
        n = 0;
        while (led !== val && n < maxc) begin
            cyc(1);
            n++;
        end
        if (led !== val) begin
            checks++; errors++;
            $display("FAIL %s timeout got=%h exp=%h", name, led, val);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int n;
        int wraps, first_wrap;
        rst = 1'b1;
        en_a = 1'b1; en_b = 1'b0; pause = 1'b0; mode = 2'd0; div_val = 3;
        cyc(2);
        check("reset_led", 32'(led), 32'h01);
        check("reset_tick", 32'(step_tick), 0);
        check("reset_wrap", 32'(wrap), 0);
        rst = 1'b0;

        // 1: LEFT, div 3
        for (int k = 1; k <= 32; k++) begin
            cyc(1);
            if (k == 3)  check("s1_hold", 32'(led), 32'h01);
            if (k == 4)  check("s1_first_step", 32'({led, step_tick}), 32'h005);
            if (k == 28) check("s1_msb", 32'(led), 32'h80);
            if (k == 32) check("s1_wrap", 32'({led, step_tick, wrap}), 32'h007);
        end

        // 2: BOUNCE, div 0
        mode = 2'd2; div_val = 0; en_a = 1'b0; en_b = 1'b1;
        cyc(1);
        check("s2_modechg", 32'({led, step_tick}), 32'h002);
        wraps = 0; first_wrap = 0;
        for (int k = 1; k <= 28; k++) begin
            cyc(1);
            if (wrap) begin
                wraps++;
                if (first_wrap == 0) first_wrap = k;
            end
            if (k == 7)  check("s2_top", 32'(led), 32'h80);
            if (k == 8)  check("s2_down", 32'(led), 32'h40);
            if (k == 14) check("s2_land", 32'({led, wrap}), 32'h003);
        end
        check("s2_wrap_count", 32'(wraps), 2);
        check("s2_first_wrap", 32'(first_wrap), 14);

        // 3: LEFT, div 9, pause at cnt 5
        mode = 2'd0; div_val = 9; en_b = 1'b0; en_a = 1'b1;
        cyc(1);
        cyc(5);
        pause = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            if (step_tick) n++;
        end
        check("s3_no_ticks", 32'(n), 0);
        check("s3_frozen_led", 32'(led), 32'h01);
        pause = 1'b0;
        wait_tick("s3_resume", 20, n);
        check("s3_resume_delay", 32'(n), 5);
        check("s3_resume_led", 32'(led), 32'h02);

        // 4: RIGHT, stop and restart
        mode = 2'd1; div_val = 2;
        cyc(1);
        check("s4_init", 32'(led), 32'h80);
        wait_led("s4_reach10", 8'h10, 40);
        en_a = 1'b0; en_b = 1'b0;
        cyc(1);
        check("s4_stop", 32'({led, step_tick}), 32'h100);
        en_b = 1'b1;
        wait_tick("s4_restart", 10, n);
        check("s4_restart_delay", 32'(n), 3);
        check("s4_restart_led", 32'(led), 32'h40);

        // 5: LEFT -> FILL mid-run
        mode = 2'd0; div_val = 1; en_a = 1'b1;
        cyc(1);
        wait_led("s5_reach08", 8'h08, 40);
        mode = 2'd3;
        cyc(1);
        check("s5_modechg", 32'({led, step_tick}), 32'h002);
        for (int s = 1; s <= 8; s++) begin
            wait_tick("s5_step", 5, n);
            if (s == 1) check("s5_fill1", 32'(led), 32'h03);
            if (s == 7) check("s5_full", 32'({led, wrap}), 32'h1FE);
            if (s == 8) check("s5_wrap", 32'({led, wrap}), 32'h003);
        end

        // 6: async reset mid-run
        mode = 2'd0; div_val = 3;
        cyc(7);
        check("s6_pre", 32'(led), 32'h02);
        #2;
        rst = 1'b1;
        #1;
        check("s6_async", 32'({led, step_tick, wrap}), 32'h004);
        cyc(1);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc(1);
            if (k == 3) check("s6_hold", 32'(led), 32'h01);
            if (k == 4) check("s6_first_step", 32'({led, step_tick}), 32'h005);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
